// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED controller.
// A shared gap timer paces duty stepping and a shared free-running PWM counter
// compares against each channel's duty register. Every channel runs its own small
// FSM (off, steady on, continuous breath, one-shot breath) selected by a 2-bit mode.
// A change of a channel's mode reloads that channel on the next clock and takes
// priority over a tick arriving on the same clock.

module breath_led_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned N            = 16,
    parameter int unsigned CLK_FREQ_MHZ = 27,
    parameter int unsigned GAP_US       = 100,
    parameter int unsigned DUTY_STEP    = 64,
    parameter int unsigned DUTY_MIN     = 4096,
    parameter int unsigned DUTY_MAX     = 65535,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led_out,
    output logic [NUM_CH-1:0]     cycle_done,
    output logic [N*NUM_CH-1:0]   duty_mon
);

    // Tick pacing: one tick every CLK_FREQ_MHZ*GAP_US clocks.
    localparam int unsigned TickPeriod = CLK_FREQ_MHZ * GAP_US;
    localparam int unsigned TickW      = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TickPeriod - 1);

    // Duty constants, sized to the PWM width. The parameter constraints keep
    // every step inside [DUTY_MIN, DUTY_MAX], so no wrap protection is needed.
    localparam logic [N-1:0] DutyMin  = N'(DUTY_MIN);
    localparam logic [N-1:0] DutyMax  = N'(DUTY_MAX);
    localparam logic [N-1:0] DutyStep = N'(DUTY_STEP);
    localparam logic [N-1:0] UpTurn   = N'(DUTY_MAX - DUTY_STEP);
    localparam logic [N-1:0] DownTurn = N'(DUTY_MIN + DUTY_STEP);

    typedef enum logic [1:0] {
        ModeOff     = 2'b00,
        ModeOn      = 2'b01,
        ModeBreath  = 2'b10,
        ModeOneshot = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        StOff  = 3'd0,
        StOn   = 3'd1,
        StUp   = 3'd2,
        StDown = 3'd3,
        StDone = 3'd4
    } state_e;

    // Shared timebase
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [N-1:0]     pwm_cnt_q, pwm_cnt_d;

    // Per-channel state
    logic [2*NUM_CH-1:0]         mode_q, mode_d;
    state_e                      state_q [NUM_CH];
    state_e                      state_d [NUM_CH];
    logic [NUM_CH-1:0][N-1:0]    duty_q, duty_d;
    logic [NUM_CH-1:0]           cycle_done_q, cycle_done_d;
    logic [NUM_CH-1:0]           led_q, led_d;
    logic [NUM_CH-1:0]           raw;

    // Gap timer and PWM counter next-state; both wrap naturally.
    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        pwm_cnt_d  = pwm_cnt_q + N'(1);
    end

    // Shared timebase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    // Channel FSMs: mode-change reload first, otherwise step the duty on a tick.
    always_comb begin
        mode_d = mode;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]      = state_q[i];
            duty_d[i]       = duty_q[i];
            cycle_done_d[i] = 1'b0;

            if (mode[2*i +: 2] != mode_q[2*i +: 2]) begin
                unique case (mode_e'(mode[2*i +: 2]))
                    ModeOff: begin
                        state_d[i] = StOff;
                        duty_d[i]  = '0;
                    end
                    ModeOn: begin
                        state_d[i] = StOn;
                        duty_d[i]  = DutyMax;
                    end
                    ModeBreath, ModeOneshot: begin
                        state_d[i] = StUp;
                        duty_d[i]  = DutyMin;
                    end
                endcase
            end else if (tick) begin
                unique case (state_q[i])
                    StUp: begin
                        if (duty_q[i] >= UpTurn) begin
                            duty_d[i]  = DutyMax;
                            state_d[i] = StDown;
                        end else begin
                            duty_d[i] = duty_q[i] + DutyStep;
                        end
                    end
                    StDown: begin
                        if (duty_q[i] <= DownTurn) begin
                            cycle_done_d[i] = 1'b1;
                            // One-shot parks dark; breath turns around at the floor.
                            if (mode_e'(mode[2*i +: 2]) == ModeOneshot) begin
                                state_d[i] = StDone;
                                duty_d[i]  = '0;
                            end else begin
                                state_d[i] = StUp;
                                duty_d[i]  = DutyMin;
                            end
                        end else begin
                            duty_d[i] = duty_q[i] - DutyStep;
                        end
                    end
                    default: begin
                        // StOff, StOn and StDone ignore ticks.
                    end
                endcase
            end
        end
    end

    // PWM compare per channel; steady-on bypasses the compare so the LED never blinks.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (state_q[i] == StOn) ? 1'b1 : (pwm_cnt_q < duty_q[i]);
        end
        led_d = raw ^ {NUM_CH{ACTIVE_LOW}};
    end

    // Channel registers; reset drops any pending cycle_done and darkens the LEDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= '0;
            duty_q       <= '0;
            cycle_done_q <= '0;
            led_q        <= {NUM_CH{ACTIVE_LOW}};
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StOff;
            end
        end else begin
            mode_q       <= mode_d;
            duty_q       <= duty_d;
            cycle_done_q <= cycle_done_d;
            led_q        <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign led_out    = led_q;
    assign cycle_done = cycle_done_q;
    assign duty_mon   = duty_q;

endmodule
